// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: FSM states, opcodes and
// the select/control codes driven onto the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_ALUWB,
        S_BRANCH,
        S_LUI,
        S_AUIPC
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // lui/auipc always get the U format, even when the FSM rejects them.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_LW, OP_I:      return IMM_I;
            OP_SW:            return IMM_S;
            OP_BR:            return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU op plus instruction fields to the ALU control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only selects sub for register-register ops; addi ignores it
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multi-cycle RV32 datapath, with a retired-instruction counter.
// Build option: define CTRL_UTYPE_EN to execute lui/auipc instead of flagging them illegal.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 -> PC when memory ready
// DECODE     | compute branch target into ALUOut, dispatch on opcode
// MEMADR     | rd1 + imm -> effective address
// MEMREAD    | load access, held until mem_ready
// MEMWB      | load data -> register file
// MEMWRITE   | store access, held until mem_ready
// EXECR/EXECI| register/immediate ALU operation
// JAL        | oldPC + 4 -> ALUOut, jump target -> PC
// ALUWB      | ALUOut -> register file
// BRANCH     | compare rd1/rd2, conditionally load PC
// LUI/AUIPC  | 0 + imm / oldPC + imm (CTRL_UTYPE_EN builds only)
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    state_t     state, state_n;
    logic [1:0] alu_op;
    logic       pc_update, branch;
    logic       mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw, retire_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            retire_cnt <= '0;
        end else begin
            state <= state_n;
            if (retire_raw)
                retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_n       = state;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        retire_raw    = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_update    = 1'b1;
                    state_n      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_JAL:       state_n = S_JAL;
                    OP_BR:        state_n = S_BRANCH;
`ifdef CTRL_UTYPE_EN
                    OP_LUI:       state_n = S_LUI;
                    OP_AUIPC:     state_n = S_AUIPC;
`endif
                    default: begin
                        // PC was already advanced in FETCH, so just move on
                        illegal_raw = 1'b1;
                        state_n     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_n   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready)
                    state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_n       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) begin
                    retire_raw = 1'b1;
                    state_n    = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
                state_n   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_n   = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
                state_n   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
                state_n       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                retire_raw = 1'b1;
                state_n    = S_FETCH;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                state_n   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_n   = S_ALUWB;
            end
            default: state_n = S_FETCH;
        endcase
    end

    // Strobes are masked by reset so a reset mid-access cannot leak a write.
    assign pc_write  = ~reset & (pc_update | (branch & (zero ^ funct3[0])));
    assign mem_write = ~reset & mem_write_raw;
    assign ir_write  = ~reset & ir_write_raw;
    assign reg_write = ~reset & reg_write_raw;
    assign illegal   = ~reset & illegal_raw;
    assign retire    = ~reset & retire_raw;
    assign imm_src   = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs are queued
// as stimulus is driven and compared at the following falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] res, a, b;
        logic [2:0] alu, imm;
        logic       ill, ret;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, funct7b5, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, retire;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control, imm_src;
    logic [3:0] retire_cnt;

    int    n_checks = 0;
    int    n_errors = 0;
    logic [3:0] exp_cnt = 4'd0;
    exp_t  q[$];
    string tq[$];

    multicycle_controller #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal),
        .retire(retire), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string t;
            e = q.pop_front();
            t = tq.pop_front();
            g = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                 alu_src_a, alu_src_b, alu_control, imm_src, illegal, retire, retire_cnt};
            check(t, 32'(g), 32'(e));
        end
    end

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011: return 3'b000;
            7'b0100011:             return 3'b001;
            7'b1100011:             return 3'b010;
            7'b1101111:             return 3'b011;
            7'b0110111, 7'b0010111: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic op5, input logic f7);
        case (f3)
            3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t base();
        exp_t e;
        e     = '0;
        e.imm = imm_of(op);
        e.cnt = exp_cnt;
        return e;
    endfunction

    task automatic push(input string tag, input exp_t e);
        q.push_back(e);
        tq.push_back(tag);
        if (e.ret) exp_cnt = exp_cnt + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic ready);
        exp_t e;
        mem_ready = ready;
        e = base();
        e.b = 2'b10; e.res = 2'b10;
        if (ready) begin e.pcw = 1'b1; e.irw = 1'b1; end
        push("fetch", e);
    endtask

    task automatic do_decode(input logic ill);
        exp_t e;
        mem_ready = 1'b1;
        e = base();
        e.a = 2'b01; e.b = 2'b01; e.ill = ill;
        push("decode", e);
    endtask

    task automatic do_aluwb();
        exp_t e;
        e = base();
        e.rw = 1'b1; e.ret = 1'b1;
        push("aluwb", e);
    endtask

    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        do_fetch(1'b1);
    endtask

    task automatic run_alu(input logic is_r, input logic [2:0] f3, input logic f7);
        exp_t e;
        start(is_r ? 7'b0110011 : 7'b0010011, f3, f7);
        do_decode(1'b0);
        e = base();
        e.a = 2'b10; e.b = is_r ? 2'b00 : 2'b01; e.alu = alu_exp(f3, is_r, f7);
        push(is_r ? "execr" : "execi", e);
        do_aluwb();
    endtask

    task automatic run_mem(input logic store, input int stall, input logic rst_mid);
        exp_t e;
        start(store ? 7'b0100011 : 7'b0000011, 3'b010, 1'b0);
        do_decode(1'b0);
        e = base();
        e.a = 2'b10; e.b = 2'b01;
        push("memadr", e);
        for (int i = 0; i < stall; i++) begin
            mem_ready = 1'b0;
            e = base();
            e.adr = 1'b1; e.mw = store;
            push(store ? "memwrite_wait" : "memread_wait", e);
        end
        if (rst_mid) begin
            reset = 1'b1;
            e = base();
            e.adr = 1'b1;
            push("reset_mid_store", e);
            reset = 1'b0;
            exp_cnt = 4'd0;
            return;
        end
        mem_ready = 1'b1;
        e = base();
        e.adr = 1'b1; e.mw = store; e.ret = store;
        push(store ? "memwrite_done" : "memread_done", e);
        if (!store) begin
            e = base();
            e.res = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
            push("memwb", e);
        end
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z);
        exp_t e;
        start(7'b1100011, f3, 1'b0);
        do_decode(1'b0);
        zero = z;
        e = base();
        e.a = 2'b10; e.alu = 3'b001; e.ret = 1'b1; e.pcw = z ^ f3[0];
        push(f3[0] ? "bne" : "beq", e);
        zero = 1'b0;
    endtask

    task automatic run_jal();
        exp_t e;
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        do_fetch(1'b0);
        do_fetch(1'b1);
        do_decode(1'b0);
        e = base();
        e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1;
        push("jal", e);
        do_aluwb();
    endtask

    task automatic run_utype(input logic [6:0] o);
        start(o, 3'b000, 1'b0);
`ifdef CTRL_UTYPE_EN
        begin
            exp_t e;
            do_decode(1'b0);
            e = base();
            e.a = (o == 7'b0110111) ? 2'b11 : 2'b01; e.b = 2'b01;
            push("utype", e);
            do_aluwb();
        end
`else
        do_decode(1'b1);
`endif
    endtask

    task automatic run_illegal(input logic [6:0] o);
        start(o, 3'b000, 1'b0);
        do_decode(1'b1);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = base();
            e.b = 2'b10; e.res = 2'b10;
            push("in_reset", e);
        end
        reset = 1'b0;

        run_alu(1'b1, 3'b000, 1'b0);
        run_alu(1'b1, 3'b000, 1'b1);
        run_alu(1'b1, 3'b111, 1'b0);
        run_alu(1'b1, 3'b110, 1'b0);
        run_alu(1'b1, 3'b010, 1'b0);
        run_alu(1'b0, 3'b000, 1'b1);
        run_alu(1'b0, 3'b010, 1'b0);
        run_mem(1'b0, 2, 1'b0);
        run_mem(1'b1, 3, 1'b0);
        run_branch(3'b000, 1'b1);
        run_branch(3'b001, 1'b1);
        run_branch(3'b001, 1'b0);
        run_branch(3'b000, 1'b0);
        run_jal();
        run_utype(7'b0110111);
        run_utype(7'b0010111);
        run_illegal(7'b0000000);
        run_illegal(7'b1110011);

        run_mem(1'b1, 2, 1'b1);
        for (int i = 0; i < 16; i++)
            run_alu(1'b1, 3'b000, 1'b0);
        op = 7'b0110011;
        do_fetch(1'b0);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected finish before 200000");
        $fatal(1);
    end

endmodule
